// File: rtl/mul_accum.sv
// mul_accum: sums COUNT unsigned products into a saturating accumulator and
// hands the total off over a valid/ready output port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/out_valid depend on the state register only. Once
// out_valid is raised, it and sum/count/overflow hold until out_ready or
// clear. clear outranks both handshakes and discards any product offered in
// the same cycle.
module mul_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [7:0]        count,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic [ACC_W:0]     add_wide;
    logic [7:0]         count_inc;

    // Handshake decode comes straight from the state register.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready && !clear;

    // One extra bit catches the carry that signals saturation.
    assign add_wide  = {1'b0, sum_q} + (ACC_W+1)'(product);
    assign count_inc = count_q + 8'd1;

    // Next-state and datapath update; clear overrides everything.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = S_IDLE;
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sum_d   = ACC_W'(product);
                        count_d = 8'd1;
                        state_d = (COUNT == 1) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (add_wide[ACC_W]) begin
                            sum_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            sum_d = add_wide[ACC_W-1:0];
                        end
                        count_d = count_inc;
                        if (count_inc == 8'(COUNT)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        sum_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and accumulator registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mul_accum.md
# mul_accum

Multiply-accumulate back end that sits directly downstream of the 4x4 `mul` unit. It consumes a stream of 8-bit products over a valid/ready handshake and sums a fixed number (`COUNT`) of them into a saturating accumulator. It then presents the total on a valid/ready output port and holds it until the consumer takes it. This block turns the combinational multiplier into a dot-product datapath for the step-2 arithmetic unit.

## Interface
- `PROD_W`, default 8: product input width, which matches the `mul` output.
- `ACC_W`, default 16: accumulator and result width. Must satisfy `ACC_W >= PROD_W`.
- `COUNT`, default 4: number of products summed into each result. Legal range is 1..255.

Ports (clock and reset first):
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clear`, input, 1: synchronous abort. Drops the current partial or finished result.
- `in_valid`, input, 1: `product` is valid this cycle.
- `in_ready`, output, 1: block can accept a product this cycle.
- `product`, input, `PROD_W`: unsigned product from `mul`.
- `out_valid`, output, 1: `sum` holds a completed result.
- `out_ready`, input, 1: consumer accepts the result this cycle.
- `sum`, output, `ACC_W`: accumulator value, unsigned.
- `count`, output, 8: number of products accepted into the current result.
- `overflow`, output, 1: sticky flag, set if the current result saturated.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
  - IDLE: `in_ready`=1 and `out_valid`=0.
  - ACCUM: `in_ready`=1 and `out_valid`=0.
  - DONE: `in_ready`=0 and `out_valid`=1.
- An input is accepted when `in_valid && in_ready && !clear`.
- Accept in IDLE:
  - `sum` <= `product` and `count` <= 1.
  - Next state is DONE if `COUNT`==1, otherwise ACCUM.
- Accept in ACCUM:
  - `sum` <= `sum` + `product`, computed at `ACC_W`+1 bits.
  - If the result exceeds 2^`ACC_W`-1, `sum` <= 2^`ACC_W`-1 and `overflow` <= 1.
  - `count` increments.
  - When the new `count` equals `COUNT`, next state is DONE, otherwise stay in ACCUM.
- Once `overflow` is set it stays set until the result is consumed, cleared, or reset.
- Accumulation stays saturated: adding to the maximum value keeps the maximum.
- If `in_valid` is low in IDLE or ACCUM, nothing changes. There is no timeout.
- Output handshake in DONE: when `out_valid && out_ready`, next state is IDLE and `sum`, `count` and `overflow` all clear to 0.
- While in DONE with `out_ready` low, `sum`, `count` and `overflow` hold stable and no input is accepted.
- `clear` (priority over every handshake):
  - Next state is IDLE and `sum`, `count` and `overflow` clear to 0.
  - Any product presented in the same cycle is discarded.
  - A pending result in DONE is discarded without handshake.
- `rst` asynchronously forces IDLE with `sum`=0, `count`=0, `overflow`=0 and `out_valid`=0. It may assert at any cycle, including mid-accumulation or in DONE.

## Timing
- Reset values: `out_valid`=0, `sum`=0, `count`=0, `overflow`=0, `in_ready`=1 (state IDLE).
- `in_ready` and `out_valid` are decoded from the state register only. They have no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the clock edge that accepts the `COUNT`-th product. The result is visible in the following cycle.
- No input is accepted in the cycle the result is handed off. With back-to-back inputs and `out_ready` held at 1, minimum spacing is `COUNT`+1 cycles per result.
- `sum` and `count` update on the accepting edge, so partial sums are observable during ACCUM.
- After the output handshake edge, `in_ready`=1 and the next product may be accepted in that cycle.

## Test plan
1. Reset: assert `rst` asynchronously mid-cycle. Required response: `out_valid`=0, `sum`=0, `count`=0, `overflow`=0 and `in_ready`=1 immediately, before the next clock edge.
2. Basic accumulation (`COUNT`=4, `ACC_W`=16): products 15, 15, 225, 0 on consecutive cycles. Required response:
   - `sum` goes 15, 30, 255, 255.
   - `out_valid` goes to 1 after the 4th accept, with `count`=4 and `overflow`=0.
   - With `out_ready`=1, the block returns to IDLE one cycle later with `sum`=0.
3. Backpressure:
   - Hold `out_ready`=0 for 3 cycles in DONE while driving `in_valid`=1 with `product`=9. Required response: `sum`=255 stable, `in_ready`=0, and the product is not accepted.
   - Then raise `out_ready`. Required response: a single handshake, then `product`=9 is accepted as the first term of the next result.
4. Saturation (`ACC_W`=8, `COUNT`=4): products 225, 225, 1, 0. Required response: `sum` goes 225, 255, 255, 255 and `overflow` goes 0, 1, 1, 1. The final result is 255 with `overflow`=1, and `overflow` clears on the handshake.
5. Clear mid-operation:
   - After 2 accepts (`sum`=30), pulse `clear` together with `in_valid` and `product`=7. Required response: `sum`=0, `count`=0 and IDLE, and the 7 is dropped.
   - Then send products 1, 2, 3, 4. Required response: result 10.
6. Idle gaps and `COUNT`=1: with `COUNT`=4, insert random `in_valid`=0 gaps into product sequence 3, 3, 3, 3. Required response: result 12. With `COUNT`=1, product 50 gives `out_valid` in the next cycle with `sum`=50.
